// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types and constants for the interrupt controller
package intc_pkg;

  typedef enum logic [1:0] {
    ENABLE  = 2'd0,
    PENDING = 2'd1,
    VECTOR  = 2'd2,
    EOI     = 2'd3
  } intc_reg_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } intc_state_e;

  localparam int INTC_ACTIVE_BIT = 31;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-first priority encoder, purely combinational
module int_prio_enc #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan downwards so the lowest set index is the last one assigned.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller: edge detect, pending/enable, hwint handshake, register bus
module int_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               hwint,
  input  logic               int_ack,
  input  logic [1:0]         reg_sel,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out
);

  localparam int VEC_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  intc_state_e          state_q, state_d;
  logic                 hwint_q, hwint_d;
  logic                 active_q, active_d;
  logic [VEC_WIDTH-1:0] vec_q, vec_d;
  logic [NUM_SRC-1:0]   enable_q, enable_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   irq_prev_q, irq_prev_d;

  intc_reg_e            sel;
  logic                 req;
  logic [VEC_WIDTH-1:0] win_idx;
  logic [NUM_SRC-1:0]   win_mask;
  logic [NUM_SRC-1:0]   set_mask;
  logic [NUM_SRC-1:0]   clr_mask;
  logic [31:0]          rd_data;

  assign sel = intc_reg_e'(reg_sel);

  int_prio_enc #(.N(NUM_SRC), .W(VEC_WIDTH)) u_prio (
    .req   (pending_q & enable_q),
    .valid (req),
    .idx   (win_idx)
  );

  assign win_mask = req ? (NUM_SRC'(1) << win_idx) : '0;

  always_comb begin
    irq_prev_d = irq_src;
    set_mask   = irq_src & ~irq_prev_q;
    clr_mask   = '0;
    state_d    = state_q;
    hwint_d    = hwint_q;
    active_d   = active_q;
    vec_d      = vec_q;
    enable_d   = enable_q;

    if (wr && sel == ENABLE)  enable_d = data_in[NUM_SRC-1:0];
    if (wr && sel == PENDING) clr_mask = data_in[NUM_SRC-1:0];

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = REQ;
          hwint_d = 1'b1;
        end
      end
      REQ: begin
        // An ack in the same cycle as a withdrawal still takes the grant.
        if (int_ack) begin
          vec_d    = win_idx;
          clr_mask = clr_mask | win_mask;
          active_d = 1'b1;
          state_d  = ACTIVE;
          hwint_d  = 1'b0;
        end else if (!req) begin
          state_d = IDLE;
          hwint_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (wr && sel == EOI) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        hwint_d = 1'b0;
      end
    endcase

    // A fresh edge beats any clear of the same bit.
    pending_d = set_mask | (pending_q & ~clr_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hwint_q    <= 1'b0;
      active_q   <= 1'b0;
      vec_q      <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      hwint_q    <= hwint_d;
      active_q   <= active_d;
      vec_q      <= vec_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_prev_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (sel)
      ENABLE:  rd_data = 32'(enable_q);
      PENDING: rd_data = 32'(pending_q);
      VECTOR: begin
        rd_data[VEC_WIDTH-1:0]  = vec_q;
        rd_data[INTC_ACTIVE_BIT] = active_q;
      end
      EOI:     rd_data = '0;
      default: rd_data = '0;
    endcase
  end

  assign hwint    = hwint_q;
  assign data_out = rd ? rd_data : 32'h0;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed and randomized checks of int_ctrl against a behavioural model
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irq_src = '0;
  logic        hwint;
  logic        int_ack = 1'b0;
  logic [1:0]  reg_sel = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;

  int tests  = 0;
  int failed = 0;
  bit chk_on = 1'b0;

  int_ctrl #(.NUM_SRC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .hwint    (hwint),
    .int_ack  (int_ack),
    .reg_sel  (reg_sel),
    .rd       (rd),
    .wr       (wr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Model: controller is "asserting" (m_hwint), "serving" (m_active) or neither.
  logic [7:0] m_en, m_pend, m_prev;
  logic       m_hwint, m_active;
  int         m_vec;

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_rd();
    if (!rd) return 32'h0;
    case (reg_sel)
      2'd0:    return {24'h0, m_en};
      2'd1:    return {24'h0, m_pend};
      2'd2:    return {m_active, 28'h0, m_vec[2:0]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en = '0; m_pend = '0; m_prev = '0;
      m_hwint = 1'b0; m_active = 1'b0; m_vec = 0;
    end else begin
      logic [7:0] set, clr, live;
      set  = irq_src & ~m_prev;
      live = m_pend & m_en;
      clr  = (wr && reg_sel == 2'd1) ? data_in[7:0] : 8'h0;
      if (m_hwint) begin
        if (int_ack) begin
          m_vec    = lowest(live);
          if (live != 0) clr = clr | (8'h1 << m_vec);
          m_active = 1'b1;
          m_hwint  = 1'b0;
        end else if (live == 0) begin
          m_hwint = 1'b0;
        end
      end else if (m_active) begin
        if (wr && reg_sel == 2'd3) m_active = 1'b0;
      end else if (live != 0) begin
        m_hwint = 1'b1;
      end
      m_pend = set | (m_pend & ~clr);
      if (wr && reg_sel == 2'd0) m_en = data_in[7:0];
      m_prev = irq_src;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_hwint", {31'h0, hwint}, {31'h0, m_hwint});
      chk("model_data_out", data_out, model_rd());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [31:0] d);
    wr = 1'b1; reg_sel = sel; data_in = d;
    step(1);
    wr = 1'b0; data_in = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] sel, input logic [31:0] exp);
    rd = 1'b1; reg_sel = sel;
    #1;
    chk(name, data_out, exp);
    rd = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq_src = irq_src | m;
    step(1);
    irq_src = irq_src & ~m;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b1;
    chk_on = 1'b1;
    step(1);
    chk("reset_hwint", {31'h0, hwint}, 32'h0);
    rd_chk("reset_enable", 2'd0, 32'h0);

    // Basic
    wr_reg(2'd0, 32'h04);
    pulse_irq(8'h04);
    chk("basic_hwint_lat1", {31'h0, hwint}, 32'h0);
    step(1);
    chk("basic_hwint_lat2", {31'h0, hwint}, 32'h1);
    ack();
    chk("basic_hwint_ack", {31'h0, hwint}, 32'h0);
    rd_chk("basic_vector", 2'd2, 32'h8000_0002);
    rd_chk("basic_pending", 2'd1, 32'h0);
    wr_reg(2'd3, 32'h0);

    // Priority
    wr_reg(2'd0, 32'hFF);
    pulse_irq(8'h22);
    step(1);
    chk("prio_hwint", {31'h0, hwint}, 32'h1);
    ack();
    rd_chk("prio_vec1", 2'd2, 32'h8000_0001);
    rd_chk("prio_pend", 2'd1, 32'h20);
    wr_reg(2'd3, 32'hDEAD);
    step(1);
    chk("prio_reraise", {31'h0, hwint}, 32'h1);
    ack();
    rd_chk("prio_vec5", 2'd2, 32'h8000_0005);
    wr_reg(2'd3, 32'h0);
    step(2);

    // Masking
    wr_reg(2'd0, 32'h0);
    pulse_irq(8'h08);
    rd_chk("mask_pend", 2'd1, 32'h08);
    step(3);
    chk("mask_hwint_off", {31'h0, hwint}, 32'h0);
    wr_reg(2'd0, 32'hFFFF_FF08);
    rd_chk("mask_enable_width", 2'd0, 32'h08);
    step(1);
    chk("mask_hwint_on", {31'h0, hwint}, 32'h1);

    // Withdraw
    wr_reg(2'd1, 32'h08);
    step(1);
    chk("withdraw_hwint", {31'h0, hwint}, 32'h0);
    rd_chk("withdraw_vector", 2'd2, 32'h0000_0005);

    // Collisions
    wr_reg(2'd0, 32'h0);
    irq_src = 8'h08; wr = 1'b1; reg_sel = 2'd1; data_in = 32'h08;
    step(1);
    wr = 1'b0; irq_src = 8'h0;
    rd_chk("coll_set_wins", 2'd1, 32'h08);
    ack();
    chk("coll_ack_idle_hwint", {31'h0, hwint}, 32'h0);
    rd_chk("coll_ack_idle_vec", 2'd2, 32'h0000_0005);
    rd_chk("coll_ack_idle_pend", 2'd1, 32'h08);
    wr_reg(2'd3, 32'h0);
    rd_chk("coll_eoi_idle_vec", 2'd2, 32'h0000_0005);
    rd_chk("coll_eoi_idle_pend", 2'd1, 32'h08);

    // Reset mid-REQ
    wr_reg(2'd0, 32'h08);
    step(1);
    chk("rst_pre_hwint", {31'h0, hwint}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_hwint", {31'h0, hwint}, 32'h0);
    rd_chk("rst_enable", 2'd0, 32'h0);
    rd_chk("rst_pending", 2'd1, 32'h0);
    step(1);
    rst = 1'b1;

    // Randomized traffic checked by the per-cycle compare process
    for (int c = 0; c < 4000; c++) begin
      irq_src = 8'($urandom & $urandom & $urandom);
      rd      = 1'($urandom);
      wr      = ($urandom_range(0, 3) == 0);
      reg_sel = 2'($urandom);
      data_in = (reg_sel == 2'd0) ? ($urandom | $urandom) : $urandom;
      int_ack = ($urandom_range(0, 2) == 0);
      rst     = ($urandom_range(0, 599) != 0);
      step(1);
    end
    rst = 1'b1; rd = 1'b0; wr = 1'b0; int_ack = 1'b0; irq_src = '0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
